// File: rtl/core_launcher.sv
// Host-side sequencer for the 9-bit core: loads program bytes into data memory,
// releases the core, waits for done (with timeout), then drains a result window.
module core_launcher #(
  parameter int unsigned LOAD_BASE    = 0,
  parameter int unsigned RESULT_BASE  = 64,
  parameter int unsigned RESULT_LEN   = 32,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data,
  output logic       core_sel,
  output logic       core_start,
  input  logic       core_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned RUN_W = $clog2(TIMEOUT);
  localparam int unsigned ST_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [7:0]       ld_cnt;
  logic [7:0]       rd_idx;
  logic [RUN_W-1:0] run_cnt;
  logic [ST_W-1:0]  st_cnt;
  logic             in_fire;
  logic             out_fire;

  // Handshake-facing outputs are gated by reset so nothing moves while it is held.
  assign in_ready    = reset & (state == S_LOAD);
  assign in_fire     = in_valid & in_ready;
  assign out_valid   = reset & (state == S_DRAIN);
  assign out_fire    = out_valid & out_ready;
  assign mem_wr_en   = in_fire;
  assign mem_wr_data = in_data;
  assign out_data    = mem_rd_data;
  assign core_start  = ~(reset & (state == S_RUN));
  assign core_sel    = reset & ((state == S_START) | (state == S_RUN));
  assign busy        = reset & ((state == S_START) | (state == S_RUN) | (state == S_DRAIN));

  // Address math wraps mod 256 by construction of the 8-bit adders.
  assign mem_addr = (state == S_DRAIN) ? (8'(RESULT_BASE) + rd_idx)
                                       : (8'(LOAD_BASE) + ld_cnt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_LOAD;
      ld_cnt  <= '0;
      rd_idx  <= '0;
      run_cnt <= '0;
      st_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            ld_cnt <= ld_cnt + 8'd1;
            if (in_last) begin
              state  <= S_START;
              st_cnt <= '0;
            end
          end
        end
        S_START: begin
          if (st_cnt == ST_W'(START_CYCLES - 1)) state <= S_RUN;
          else st_cnt <= st_cnt + ST_W'(1);
        end
        S_RUN: begin
          run_cnt <= run_cnt + RUN_W'(1);
          // A done arriving on the final allowed cycle beats the timeout.
          if (core_done) begin
            state <= S_DRAIN;
          end else if (run_cnt == RUN_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            rd_idx <= rd_idx + 8'd1;
            if (rd_idx == 8'(RESULT_LEN - 1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (in_valid) begin
            state   <= S_LOAD;
            ld_cnt  <= '0;
            rd_idx  <= '0;
            run_cnt <= '0;
            timeout <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_core_launcher.sv
// Bench for core_launcher: phase-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_core_launcher;

  localparam int unsigned LB = 254;
  localparam int unsigned RB = 64;
  localparam int unsigned RL = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned TO = 16;

  localparam int P_LOAD  = 0;
  localparam int P_START = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       core_sel;
  logic       core_start;
  logic       core_done;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       timeout;

  core_launcher #(
    .LOAD_BASE(LB), .RESULT_BASE(RB), .RESULT_LEN(RL),
    .START_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .core_sel(core_sel), .core_start(core_start), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Data memory: preset once, then written by the DUT port.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
      mem[RB]     <= 8'h11;
      mem[RB + 1] <= 8'h22;
      mem[RB + 2] <= 8'h33;
      mem[RB + 3] <= 8'h44;
      mem_ready   <= 1'b1;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase plus counts of cycles spent / bytes moved.
  int   m_ph  = P_LOAD;
  int   m_ld  = 0;
  int   m_st  = 0;
  int   m_run = 0;
  int   m_out = 0;
  logic m_tmo = 1'b0;

  always @(negedge clk) begin : compare
    logic       r;
    logic [6:0] exp_f;
    logic [6:0] act_f;
    logic [7:0] a;
    r = reset;
    exp_f = {r && m_ph == P_LOAD,
             r && m_ph == P_DRAIN,
             r && m_ph == P_LOAD && in_valid,
             !(r && m_ph == P_RUN),
             r && (m_ph == P_START || m_ph == P_RUN),
             r && (m_ph == P_START || m_ph == P_RUN || m_ph == P_DRAIN),
             m_tmo};
    act_f = {in_ready, out_valid, mem_wr_en, core_start, core_sel, busy, timeout};
    chk("flags{in_rdy,out_vld,wr_en,start,sel,busy,tmo}", 32'(act_f), 32'(exp_f));
    if (r && m_ph == P_LOAD && in_valid) begin
      a = 8'((LB + m_ld) % 256);
      chk("wr_addr", 32'(mem_addr), 32'(a));
      chk("wr_data", 32'(mem_wr_data), 32'(in_data));
    end
    if (r && m_ph == P_DRAIN) begin
      a = 8'((RB + m_out) % 256);
      chk("rd_addr", 32'(mem_addr), 32'(a));
      chk("out_data", 32'(out_data), 32'(mem[a]));
    end
    if (!r) begin
      m_ph = P_LOAD; m_ld = 0; m_out = 0; m_run = 0; m_tmo = 1'b0;
    end else begin
      case (m_ph)
        P_LOAD: if (in_valid) begin
          m_ld++;
          if (in_last) begin m_ph = P_START; m_st = 0; end
        end
        P_START: begin
          m_st++;
          if (m_st == SC) m_ph = P_RUN;
        end
        P_RUN: begin
          m_run++;
          if (core_done) m_ph = P_DRAIN;
          else if (m_run == TO) begin m_tmo = 1'b1; m_ph = P_DRAIN; end
        end
        P_DRAIN: if (out_ready) begin
          m_out++;
          if (m_out == RL) m_ph = P_DONE;
        end
        P_DONE: if (in_valid) begin
          m_ph = P_LOAD; m_ld = 0; m_out = 0; m_run = 0; m_tmo = 1'b0;
        end
        default: m_ph = P_LOAD;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Leaves the bench in the first RUN cycle; returns START length seen.
  task automatic skip_start(output int n);
    n = 0;
    while (core_start && n < 10) begin
      chk("start_core_sel", 32'(core_sel), 32'd1);
      n++;
      tick();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int         n;
    logic [7:0] pat_ready [6];
    logic [7:0] shown     [6];
    logic [7:0] exp_shown [6];
    logic [7:0] exp_res   [4];
    pat_ready = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
    exp_shown = '{8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44};
    exp_res   = '{8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0;
    core_done = 1'b0; out_ready = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_core_start", 32'(core_start), 32'd1);
    end
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Load with address wrap and a bubble
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    tick();
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    skip_start(n);
    chk("start_len", 32'(n), 32'd2);
    chk("run_core_start", 32'(core_start), 32'd0);
    chk("mem254", 32'(mem[254]), 32'hA0);
    chk("mem255", 32'(mem[255]), 32'hA1);
    chk("mem0", 32'(mem[0]), 32'hA2);
    chk("mem1", 32'(mem[1]), 32'hA3);
    chk("mem2_untouched", 32'(mem[2]), 32'hFF);

    // Normal run: done sampled at end of the 10th RUN cycle
    repeat (9) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("drain_entry_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      out_ready = pat_ready[i][0];
      #1;
      shown[i] = out_data;
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) chk("stall_data", 32'(shown[i]), 32'(exp_shown[i]));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_out_valid", 32'(out_valid), 32'd0);
    chk("done_timeout", 32'(timeout), 32'd0);

    // Timeout: core_done never rises
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("reload_mem254", 32'(mem[254]), 32'h5A);
    skip_start(n);
    chk("start_len2", 32'(n), 32'd2);
    n = 0;
    while (!core_start && n < 40) begin n++; tick(); end
    chk("run_len_timeout", 32'(n), 32'd16);
    chk("timeout_set", 32'(timeout), 32'd1);
    chk("timeout_drain_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("timeout_byte", 32'(out_data), 32'(exp_res[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("timeout_done_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    chk("timeout_sticky", 32'(timeout), 32'd1);

    // Boundary: done on the 16th RUN cycle wins over timeout
    in_valid = 1'b1; in_data = 8'h6B; in_last = 1'b1;
    tick();
    chk("done_to_load_clears_timeout", 32'(timeout), 32'd0);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    skip_start(n);
    repeat (15) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("boundary_drain", 32'(out_valid), 32'd1);
    chk("boundary_timeout", 32'(timeout), 32'd0);

    // Reset mid-DRAIN after two bytes
    out_ready = 1'b1;
    tick();
    tick();
    chk("third_byte", 32'(out_data), 32'h33);
    reset = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_core_start", 32'(core_start), 32'd1);
    reset = 1'b1; out_ready = 1'b0;
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_timeout", 32'(timeout), 32'd0);
    in_valid = 1'b1; in_data = 8'h7C; in_last = 1'b1;
    #1;
    chk("post_rst_addr", 32'(mem_addr), 32'd254);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("post_rst_mem254", 32'(mem[254]), 32'h7C);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
